// File: rtl/dmem_hs.sv
// Byte-addressable little-endian data memory with valid/ready handshake,
// programmable access latency, sized loads/stores and an error response.
module dmem_hs #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [63:0] i_req_addr,
   input  logic [63:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [63:0] o_resp_rdata,
   output logic        o_resp_err
);
   localparam int NW = (DEPTH + 7) / 8;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_write;
   logic [1:0]    r_size;
   logic          r_unsigned;
   logic [63:0]   r_addr;
   logic [63:0]   r_wdata;

   // Word-organised storage: every legal (aligned) access falls inside one word.
   logic [63:0]   r_mem [NW];

   logic [3:0]    w_nbytes;
   logic [64:0]   w_end;
   logic          w_misal;
   logic          w_oor;
   logic          w_err;
   logic [2:0]    w_off;
   logic [IW-1:0] w_idx;
   logic          w_access;
   logic [63:0]   w_word;
   logic [63:0]   w_shift;
   logic [63:0]   w_lane;
   logic [63:0]   w_load;
   logic [7:0]    w_be;

   assign w_nbytes = 4'd1 << r_size;
   assign w_end    = {1'b0, r_addr} + {61'd0, w_nbytes};
   assign w_misal  = (r_addr[2:0] & (w_nbytes[2:0] - 3'd1)) != 3'd0;
   assign w_oor    = w_end > 65'(DEPTH);
   assign w_err    = w_misal || w_oor;
   assign w_off    = r_addr[2:0];
   assign w_idx    = r_addr[IW+2:3];
   assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
   assign w_word   = r_mem[w_idx];
   assign w_shift  = w_word >> {w_off, 3'b000};
   assign w_lane   = r_wdata << {w_off, 3'b000};

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_be
         assign w_be[gi] = ({1'b0, w_off} <= 4'(gi)) &&
                           (4'(gi) < ({1'b0, w_off} + w_nbytes));
      end
   endgenerate

   always_comb begin
      w_load = '0;
      unique case (r_size)
         2'd0: w_load = {{56{w_shift[7]  & ~r_unsigned}}, w_shift[7:0]};
         2'd1: w_load = {{48{w_shift[15] & ~r_unsigned}}, w_shift[15:0]};
         2'd2: w_load = {{32{w_shift[31] & ~r_unsigned}}, w_shift[31:0]};
         2'd3: w_load = w_shift;
      endcase
   end

   // Gated by the asynchronously reset state, so a reset in WAIT drops the store.
   always_ff @(posedge clk) begin
      if (w_access && r_write && !w_err) begin
         for (int i = 0; i < 8; i++) begin
            if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_lane[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_write      <= 1'b0;
         r_size       <= 2'd0;
         r_unsigned   <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= '0;
         o_resp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_write     <= i_req_write;
                  r_size      <= i_req_size;
                  r_unsigned  <= i_req_unsigned;
                  r_addr      <= i_req_addr;
                  r_wdata     <= i_req_wdata;
                  r_cnt       <= CW'(LATENCY - 1);
                  o_req_ready <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  o_resp_valid <= 1'b1;
                  o_resp_rdata <= (w_err || r_write) ? 64'd0 : w_load;
                  o_resp_err   <= w_err;
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (i_resp_ready) begin
                  o_resp_valid <= 1'b0;
                  o_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_hs.sv
// Scoreboard bench for dmem_hs: three instances (LATENCY 1/3/4) driven by the
// same directed + random sequence and checked against a byte-array model.
module tb_dmem_hs;
   localparam int DEPTH = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit done [3];

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_inst
         localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;

         logic        rst_n, req_valid, req_ready, req_write, req_unsigned;
         logic        resp_valid, resp_ready, resp_err;
         logic [1:0]  req_size;
         logic [63:0] req_addr, req_wdata, resp_rdata;

         exp_t        q[$];
         logic [7:0]  mem_m [DEPTH];

         dmem_hs #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_req_valid   (req_valid),
            .o_req_ready   (req_ready),
            .i_req_write   (req_write),
            .i_req_size    (req_size),
            .i_req_unsigned(req_unsigned),
            .i_req_addr    (req_addr),
            .i_req_wdata   (req_wdata),
            .o_resp_valid  (resp_valid),
            .i_resp_ready  (resp_ready),
            .o_resp_rdata  (resp_rdata),
            .o_resp_err    (resp_err)
         );

         // Reference: plain byte array, little-endian assembly, arithmetic range test.
         function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic un,
                                        input logic [63:0] a, input logic [63:0] wd);
            exp_t        e;
            int          n;
            logic [64:0] endp;
            n      = 1 << sz;
            endp   = {1'b0, a} + 65'(n);
            e.rdata = '0;
            e.due   = 0;
            e.err   = ((a % 64'(n)) != 0) || (endp > 65'(DEPTH));
            if (!e.err) begin
               if (wr) begin
                  for (int i = 0; i < n; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
               end else begin
                  for (int i = 0; i < n; i++) e.rdata[8*i +: 8] = mem_m[int'(a) + i];
                  if (!un && n < 8 && e.rdata[8*n-1])
                     for (int i = 8*n; i < 64; i++) e.rdata[i] = 1'b1;
               end
            end
            return e;
         endfunction

         task automatic issue(input logic wr, input logic [1:0] sz, input logic un,
                              input logic [63:0] a, input logic [63:0] wd,
                              input int stall, input bit push);
            exp_t e;
            int   t;
            t = 0;
            while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
            req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
            req_addr = a; req_wdata = wd;
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_wdata = {$urandom, $urandom};
            req_addr  = {$urandom, $urandom};
            req_size  = 2'($urandom_range(0, 3));
            if (!push) return;
            e     = model(wr, sz, un, a, wd);
            e.due = cyc + LAT;
            q.push_back(e);
            t = 0;
            while (!resp_valid && t < 200) begin @(posedge clk); #1; t++; end
            chk($sformatf("L%0d resp_arrives", LAT), 64'(resp_valid), 64'd1);
            repeat (stall) begin @(posedge clk); #1; end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            chk($sformatf("L%0d req_ready_after_hs", LAT), 64'(req_ready), 64'd1);
            chk($sformatf("L%0d valid_drop_after_hs", LAT), 64'(resp_valid), 64'd0);
         endtask

         // Monitor: timing, stability while stalled, and data/err at handshake.
         logic        prev_valid = 1'b0, prev_hs = 1'b0;
         logic [63:0] prev_rdata = '0;
         always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
               prev_valid = 1'b0;
               prev_hs    = 1'b0;
            end else begin
               if (resp_valid) begin
                  chk($sformatf("L%0d req_ready_in_resp", LAT), 64'(req_ready), 64'd0);
                  if (!prev_valid) begin
                     if (q.size() == 0)
                        chk($sformatf("L%0d unexpected_resp", LAT), 64'(resp_valid), 64'd0);
                     else
                        chk($sformatf("L%0d resp_cycle", LAT), 64'(cyc), 64'(q[0].due));
                  end else if (!prev_hs) begin
                     chk($sformatf("L%0d rdata_stable", LAT), resp_rdata, prev_rdata);
                  end
                  if (resp_ready && q.size() > 0) begin
                     e = q.pop_front();
                     chk($sformatf("L%0d rdata", LAT), resp_rdata, e.rdata);
                     chk($sformatf("L%0d err", LAT), 64'(resp_err), 64'(e.err));
                  end
               end
               prev_valid = resp_valid;
               prev_hs    = resp_valid && resp_ready;
               prev_rdata = resp_rdata;
            end
         end

         initial begin
            int          r, n;
            logic [1:0]  sz;
            logic [63:0] a;
            rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_write = 1'b0;
            req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("L%0d rst_req_ready", LAT), 64'(req_ready), 64'd1);
            chk($sformatf("L%0d rst_resp_valid", LAT), 64'(resp_valid), 64'd0);
            chk($sformatf("L%0d rst_rdata", LAT), resp_rdata, 64'd0);
            chk($sformatf("L%0d rst_err", LAT), 64'(resp_err), 64'd0);
            rst_n = 1'b1;
            @(posedge clk); #1;

            for (int w = 0; w < DEPTH / 8; w++)
               issue(1'b1, 2'd3, 1'b0, 64'(w * 8), {$urandom, $urandom}, 0, 1'b1);

            issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 0, 1'b1);
            issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 0, 1'b1);
            issue(1'b1, 2'd0, 1'b0, 64'h21, 64'h80, 0, 1'b1);
            issue(1'b0, 2'd0, 1'b0, 64'h21, 64'h0, 0, 1'b1);
            issue(1'b0, 2'd0, 1'b1, 64'h21, 64'h0, 0, 1'b1);
            issue(1'b0, 2'd0, 1'b1, 64'h20, 64'h0, 0, 1'b1);
            issue(1'b0, 2'd0, 1'b1, 64'h22, 64'h0, 0, 1'b1);
            issue(1'b0, 2'd2, 1'b0, 64'h12, 64'h0, 0, 1'b1);
            issue(1'b1, 2'd3, 1'b0, 64'h1FC, 64'hDEADBEEFDEADBEEF, 0, 1'b1);
            issue(1'b0, 2'd3, 1'b0, 64'h1F8, 64'h0, 0, 1'b1);
            issue(1'b0, 2'd2, 1'b0, 64'h1FC, 64'h0, 0, 1'b1);
            issue(1'b0, 2'd0, 1'b0, 64'h1_0000_0000, 64'h0, 0, 1'b1);
            issue(1'b0, 2'd1, 1'b0, 64'(DEPTH - 2), 64'h0, 0, 1'b1);
            issue(1'b0, 2'd1, 1'b0, 64'(DEPTH - 1), 64'h0, 0, 1'b1);
            issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 3, 1'b1);

            // Store interrupted by reset in WAIT must leave memory untouched.
            issue(1'b1, 2'd3, 1'b0, 64'h40, 64'hAAAAAAAAAAAAAAAA, 0, 1'b1);
            issue(1'b1, 2'd3, 1'b0, 64'h40, 64'h5555555555555555, 0, 1'b0);
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
            @(negedge clk);
            chk($sformatf("L%0d post_rst_req_ready", LAT), 64'(req_ready), 64'd1);
            chk($sformatf("L%0d post_rst_resp_valid", LAT), 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
            issue(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 0, 1'b1);

            for (int k = 0; k < 80; k++) begin
               r  = $urandom_range(0, 9);
               sz = 2'($urandom_range(0, 3));
               n  = 1 << sz;
               if (r <= 5)      a = 64'($urandom_range(0, DEPTH / n - 1) * n);
               else if (r == 6) a = 64'($urandom_range(0, DEPTH - 1));
               else if (r == 7) a = 64'(DEPTH - n + n * $urandom_range(0, 1));
               else if (r == 8) a = {$urandom, $urandom};
               else             a = 64'(DEPTH - $urandom_range(1, 8));
               issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                     {$urandom, $urandom}, $urandom_range(0, 2), 1'b1);
            end
            done[gi] = 1'b1;
         end
      end
   endgenerate

   initial begin
      for (int t = 0; t < 50000; t++) begin
         @(posedge clk);
         if (done[0] && done[1] && done[2]) break;
      end
      if (!(done[0] && done[1] && done[2])) begin
         n_cmp++;
         n_bad++;
         $display("FAIL global_timeout: got %0d %0d %0d done expected 1 1 1", done[0], done[1], done[2]);
      end
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
